// File: rtl/core_encode_pkg.sv
// Shared definitions for the instruction encoder: request op codes, ISA field
// constants, FSM states and the per-format word assembly helpers.
package core_encode_pkg;

  typedef enum logic [5:0] {
    ENC_ADDI = 6'd0, ENC_SLTI, ENC_SLTIU, ENC_XORI, ENC_ORI, ENC_ANDI,
    ENC_SLLI, ENC_SRLI, ENC_SRAI,
    ENC_ADD, ENC_SUB, ENC_SLL, ENC_SLT, ENC_SLTU, ENC_XOR, ENC_SRL, ENC_SRA,
    ENC_OR, ENC_AND,
    ENC_LB, ENC_LH, ENC_LW, ENC_LBU, ENC_LHU,
    ENC_SB, ENC_SH, ENC_SW,
    ENC_BEQ, ENC_BNE, ENC_BLT, ENC_BGE, ENC_BLTU, ENC_BGEU,
    ENC_LUI, ENC_AUIPC, ENC_JAL, ENC_JALR, ENC_IN, ENC_OUT,
    ENC_MVPTG, ENC_MVGTP, ENC_MVGTO, ENC_MVNPCTG, ENC_MVGTNPC, ENC_IRET,
    ENC_LI, ENC_NOP
  } enc_op_e;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_IO     = 7'b0101011;
  localparam logic [6:0] OPC_PRIV   = 7'b1011011;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLL   = 3'b001;
  localparam logic [2:0] F3_SLT   = 3'b010;
  localparam logic [2:0] F3_SLTU  = 3'b011;
  localparam logic [2:0] F3_XOR   = 3'b100;
  localparam logic [2:0] F3_SR    = 3'b101;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_B     = 3'b000;
  localparam logic [2:0] F3_H     = 3'b001;
  localparam logic [2:0] F3_W     = 3'b010;
  localparam logic [2:0] F3_BU    = 3'b100;
  localparam logic [2:0] F3_HU    = 3'b101;
  localparam logic [2:0] F3_BEQ   = 3'b000;
  localparam logic [2:0] F3_BNE   = 3'b001;
  localparam logic [2:0] F3_BLT   = 3'b100;
  localparam logic [2:0] F3_BGE   = 3'b101;
  localparam logic [2:0] F3_BLTU  = 3'b110;
  localparam logic [2:0] F3_BGEU  = 3'b111;
  localparam logic [2:0] F3_IN    = 3'b001;
  localparam logic [2:0] F3_OUT   = 3'b000;
  localparam logic [2:0] F3_MVP   = 3'b000;
  localparam logic [2:0] F3_MVGTO = 3'b001;
  localparam logic [2:0] F3_NPC   = 3'b010;
  localparam logic [2:0] F3_IRET  = 3'b111;
  localparam logic [6:0] F7_ZERO  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EMIT1 = 2'd1, ST_EMIT2 = 2'd2} enc_state_e;

  typedef enum logic [2:0] {
    FMT_I = 3'd0, FMT_SH = 3'd1, FMT_R = 3'd2, FMT_S = 3'd3,
    FMT_B = 3'd4, FMT_U = 3'd5, FMT_J = 3'd6, FMT_LI = 3'd7
  } enc_fmt_e;

  // Register fields a format carries, as {rd, rs1, rs2}.
  function automatic logic [2:0] fmt_mask(input enc_fmt_e f);
    case (f)
      FMT_I, FMT_SH: fmt_mask = 3'b110;
      FMT_R:         fmt_mask = 3'b111;
      FMT_S, FMT_B:  fmt_mask = 3'b011;
      default:       fmt_mask = 3'b100;
    endcase
  endfunction

  // True when v is representable as a signed value of msb+1 bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] t;
    t = 32'($signed(v) >>> msb);
    return (t == 32'h0000_0000) || (t == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] i, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {i, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] s, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] opc);
    return {s[11:5], rs2, rs1, f3, s[4:0], opc};
  endfunction

  // b holds offset bits [12:1]; bit 0 is always zero in a legal branch.
  function automatic logic [31:0] enc_b(input logic [11:0] b, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] opc);
    return {b[11], b[9:4], rs2, rs1, f3, b[3:0], b[10], opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] u, input logic [4:0] rd,
      input logic [6:0] opc);
    return {u, rd, opc};
  endfunction

  // j holds offset bits [20:1].
  function automatic logic [31:0] enc_j(input logic [19:0] j, input logic [4:0] rd,
      input logic [6:0] opc);
    return {j[19], j[9:0], j[10], j[18:11], rd, opc};
  endfunction

endpackage

// File: rtl/core_encode_fmt.sv
// Combinational encoder: symbolic request -> one or two instruction words,
// plus the legality verdict from the immediate range checks.
module core_encode_fmt
  import core_encode_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [31:0]     imm,
  output logic [31:0]     word0,
  output logic [31:0]     word1,
  output logic            two_words,
  output logic            illegal
);
  enc_fmt_e    fmt_s;
  logic [6:0]  opc_s;
  logic [6:0]  f7_s;
  logic [2:0]  f3_s;
  logic [2:0]  keep_s;
  logic [2:0]  mask_s;
  logic        bad_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [19:0] hi_s;

  // Per-op format, major opcode, function fields and used register fields.
  always_comb begin
    fmt_s = FMT_I; opc_s = OPC_OPIMM; f3_s = F3_ADD; f7_s = F7_ZERO;
    keep_s = 3'b111; bad_s = 1'b0;
    case (enc_op_e'(op))
      ENC_ADDI:    f3_s = F3_ADD;
      ENC_SLTI:    f3_s = F3_SLT;
      ENC_SLTIU:   f3_s = F3_SLTU;
      ENC_XORI:    f3_s = F3_XOR;
      ENC_ORI:     f3_s = F3_OR;
      ENC_ANDI:    f3_s = F3_AND;
      ENC_SLLI:    begin fmt_s = FMT_SH; f3_s = F3_SLL; end
      ENC_SRLI:    begin fmt_s = FMT_SH; f3_s = F3_SR; end
      ENC_SRAI:    begin fmt_s = FMT_SH; f3_s = F3_SR; f7_s = F7_ALT; end
      ENC_ADD:     begin fmt_s = FMT_R; opc_s = OPC_OP; end
      ENC_SUB:     begin fmt_s = FMT_R; opc_s = OPC_OP; f7_s = F7_ALT; end
      ENC_SLL:     begin fmt_s = FMT_R; opc_s = OPC_OP; f3_s = F3_SLL; end
      ENC_SLT:     begin fmt_s = FMT_R; opc_s = OPC_OP; f3_s = F3_SLT; end
      ENC_SLTU:    begin fmt_s = FMT_R; opc_s = OPC_OP; f3_s = F3_SLTU; end
      ENC_XOR:     begin fmt_s = FMT_R; opc_s = OPC_OP; f3_s = F3_XOR; end
      ENC_SRL:     begin fmt_s = FMT_R; opc_s = OPC_OP; f3_s = F3_SR; end
      ENC_SRA:     begin fmt_s = FMT_R; opc_s = OPC_OP; f3_s = F3_SR; f7_s = F7_ALT; end
      ENC_OR:      begin fmt_s = FMT_R; opc_s = OPC_OP; f3_s = F3_OR; end
      ENC_AND:     begin fmt_s = FMT_R; opc_s = OPC_OP; f3_s = F3_AND; end
      ENC_LB:      begin opc_s = OPC_LOAD; f3_s = F3_B; end
      ENC_LH:      begin opc_s = OPC_LOAD; f3_s = F3_H; end
      ENC_LW:      begin opc_s = OPC_LOAD; f3_s = F3_W; end
      ENC_LBU:     begin opc_s = OPC_LOAD; f3_s = F3_BU; end
      ENC_LHU:     begin opc_s = OPC_LOAD; f3_s = F3_HU; end
      ENC_SB:      begin fmt_s = FMT_S; opc_s = OPC_STORE; f3_s = F3_B; end
      ENC_SH:      begin fmt_s = FMT_S; opc_s = OPC_STORE; f3_s = F3_H; end
      ENC_SW:      begin fmt_s = FMT_S; opc_s = OPC_STORE; f3_s = F3_W; end
      ENC_BEQ:     begin fmt_s = FMT_B; opc_s = OPC_BRANCH; f3_s = F3_BEQ; end
      ENC_BNE:     begin fmt_s = FMT_B; opc_s = OPC_BRANCH; f3_s = F3_BNE; end
      ENC_BLT:     begin fmt_s = FMT_B; opc_s = OPC_BRANCH; f3_s = F3_BLT; end
      ENC_BGE:     begin fmt_s = FMT_B; opc_s = OPC_BRANCH; f3_s = F3_BGE; end
      ENC_BLTU:    begin fmt_s = FMT_B; opc_s = OPC_BRANCH; f3_s = F3_BLTU; end
      ENC_BGEU:    begin fmt_s = FMT_B; opc_s = OPC_BRANCH; f3_s = F3_BGEU; end
      ENC_LUI:     begin fmt_s = FMT_U; opc_s = OPC_LUI; end
      ENC_AUIPC:   begin fmt_s = FMT_U; opc_s = OPC_AUIPC; end
      ENC_JAL:     begin fmt_s = FMT_J; opc_s = OPC_JAL; end
      ENC_JALR:    opc_s = OPC_JALR;
      ENC_IN:      begin opc_s = OPC_IO; f3_s = F3_IN; end
      ENC_OUT:     begin opc_s = OPC_IO; f3_s = F3_OUT; end
      ENC_MVPTG:   begin fmt_s = FMT_R; opc_s = OPC_PRIV; keep_s = 3'b110; end
      ENC_MVGTP:   begin fmt_s = FMT_R; opc_s = OPC_PRIV; f7_s = F7_ALT; keep_s = 3'b110; end
      ENC_MVGTO:   begin fmt_s = FMT_R; opc_s = OPC_PRIV; f3_s = F3_MVGTO; keep_s = 3'b010; end
      ENC_MVNPCTG: begin fmt_s = FMT_R; opc_s = OPC_PRIV; f3_s = F3_NPC; keep_s = 3'b100; end
      ENC_MVGTNPC: begin fmt_s = FMT_R; opc_s = OPC_PRIV; f3_s = F3_NPC; f7_s = F7_ALT; keep_s = 3'b010; end
      ENC_IRET:    begin fmt_s = FMT_R; opc_s = OPC_PRIV; f3_s = F3_IRET; keep_s = 3'b000; end
      ENC_LI:      fmt_s = FMT_LI;
      ENC_NOP:     begin fmt_s = FMT_R; keep_s = 3'b000; end
      default:     bad_s = 1'b1;
    endcase
  end

  assign mask_s = keep_s & fmt_mask(fmt_s);
  assign rd_s   = mask_s[2] ? rd  : 5'd0;
  assign rs1_s  = mask_s[1] ? rs1 : 5'd0;
  assign rs2_s  = mask_s[0] ? rs2 : 5'd0;
  // LUI part of LI is rounded so the sign-extended ADDI low part lands exactly.
  assign hi_s   = imm[31:12] + {19'd0, imm[11]};

  // Assemble the word(s) and apply the immediate checks of the chosen format.
  always_comb begin
    word0 = 32'h0000_0000; word1 = 32'h0000_0000; two_words = 1'b0; illegal = bad_s;
    case (fmt_s)
      FMT_I: begin
        word0   = enc_i(imm[11:0], rs1_s, f3_s, rd_s, opc_s);
        illegal = bad_s | ~fits_signed(imm, 11);
      end
      FMT_SH: begin
        word0   = enc_r(f7_s, imm[4:0], rs1_s, f3_s, rd_s, opc_s);
        illegal = bad_s | (imm[31:5] != 27'd0);
      end
      FMT_R:  word0 = enc_r(f7_s, rs2_s, rs1_s, f3_s, rd_s, opc_s);
      FMT_S: begin
        word0   = enc_s(imm[11:0], rs2_s, rs1_s, f3_s, opc_s);
        illegal = bad_s | ~fits_signed(imm, 11);
      end
      FMT_B: begin
        word0   = enc_b(imm[12:1], rs2_s, rs1_s, f3_s, opc_s);
        illegal = bad_s | imm[0] | ~fits_signed(imm, 12);
      end
      FMT_U: begin
        word0   = enc_u(imm[31:12], rd_s, opc_s);
        illegal = bad_s | (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        word0   = enc_j(imm[20:1], rd_s, opc_s);
        illegal = bad_s | imm[0] | ~fits_signed(imm, 20);
      end
      FMT_LI: begin
        word0     = enc_u(hi_s, rd, OPC_LUI);
        word1     = enc_i(imm[11:0], rd, F3_ADD, rd, OPC_OPIMM);
        two_words = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_encode.sv
// Instruction encoder top: request/word handshakes, LI two-word sequencing
// and the one-cycle error pulse for unencodable requests.
module core_encode
  import core_encode_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [OP_W-1:0] REQ_OP,
  input  logic [4:0]      REQ_RD,
  input  logic [4:0]      REQ_RS1,
  input  logic [4:0]      REQ_RS2,
  input  logic [31:0]     REQ_IMM,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [31:0]     OUT_INST,
  output logic            OUT_LAST,
  output logic            ERR,
  output logic            BUSY
);
  enc_state_e  state_r, state_n;
  logic        out_valid_r, out_valid_n;
  logic        out_last_r, out_last_n;
  logic        err_r, err_n;
  logic        busy_r;
  logic [31:0] out_inst_r, out_inst_n;
  logic [31:0] pend_r, pend_n;
  logic [31:0] word0_s, word1_s;
  logic        two_words_s, illegal_s, ready_s, accept_s, load_s;

  core_encode_fmt #(.OP_W(OP_W)) u_fmt (
    .op        (REQ_OP),
    .rd        (REQ_RD),
    .rs1       (REQ_RS1),
    .rs2       (REQ_RS2),
    .imm       (REQ_IMM),
    .word0     (word0_s),
    .word1     (word1_s),
    .two_words (two_words_s),
    .illegal   (illegal_s)
  );

  assign ready_s   = (state_r == ST_IDLE) | (out_valid_r & OUT_READY & out_last_r);
  assign accept_s  = REQ_VALID & ready_s;
  assign REQ_READY = ready_s;
  assign OUT_VALID = out_valid_r;
  assign OUT_INST  = out_inst_r;
  assign OUT_LAST  = out_last_r;
  assign ERR       = err_r;
  assign BUSY      = busy_r;

  // Next-state and output-register values.
  always_comb begin
    state_n = state_r; out_valid_n = out_valid_r; out_inst_n = out_inst_r;
    out_last_n = out_last_r; pend_n = pend_r; err_n = 1'b0; load_s = 1'b0;
    case (state_r)
      ST_IDLE: load_s = accept_s;
      ST_EMIT1, ST_EMIT2: begin
        if (OUT_READY && !out_last_r) begin
          state_n = ST_EMIT2; out_inst_n = pend_r; out_last_n = 1'b1;
        end else if (OUT_READY) begin
          load_s = accept_s; state_n = ST_IDLE; out_valid_n = 1'b0;
        end else begin
          state_n = state_r;
        end
      end
      default: begin state_n = ST_IDLE; out_valid_n = 1'b0; end
    endcase
    // An unencodable request is consumed without producing a word.
    if (load_s && illegal_s) begin
      err_n = 1'b1; state_n = ST_IDLE; out_valid_n = 1'b0;
    end else if (load_s) begin
      state_n = ST_EMIT1; out_valid_n = 1'b1; out_inst_n = word0_s;
      out_last_n = ~two_words_s; pend_n = word1_s;
    end else begin
      err_n = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE; out_valid_r <= 1'b0; out_inst_r <= 32'h0000_0000;
      out_last_r <= 1'b0; err_r <= 1'b0; busy_r <= 1'b0; pend_r <= 32'h0000_0000;
    end else begin
      state_r <= state_n; out_valid_r <= out_valid_n; out_inst_r <= out_inst_n;
      out_last_r <= out_last_n; err_r <= err_n; busy_r <= (state_n != ST_IDLE);
      pend_r <= pend_n;
    end
  end

endmodule
